// File: rtl/note_pattern_seq_pkg.sv
// Shared definitions for the note pattern sequencer: lane width, FSM encoding, lane bits.
package note_pkg;

  localparam int NOTE_LANES = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    PLAY = ST_PLAY,
    DONE = ST_DONE
  } state_t;

  localparam logic [NOTE_LANES-1:0] GREEN  = 5'b00001;
  localparam logic [NOTE_LANES-1:0] RED    = 5'b00010;
  localparam logic [NOTE_LANES-1:0] YELLOW = 5'b00100;
  localparam logic [NOTE_LANES-1:0] BLUE   = 5'b01000;
  localparam logic [NOTE_LANES-1:0] ORANGE = 5'b10000;

endpackage

// File: rtl/note_pattern_seq_if.sv
// Control/table/playback bundle for note_pattern_seq. NOTE_SEQ_LOOKAHEAD_EN adds next_notes.
interface note_pattern_seq_if #(
  parameter int LANES  = note_pkg::NOTE_LANES,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LOOP_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANES-1:0]  wr_data;
  logic              start;
  logic              stop;
  logic              beat;
  logic [ADDR_W-1:0] loop_len;
  logic [LOOP_W-1:0] loop_cnt;
  logic [LANES-1:0]  exp_notes;
  logic [ADDR_W-1:0] step;
  logic              playing;
  logic              done;
`ifdef NOTE_SEQ_LOOKAHEAD_EN
  logic [LANES-1:0]  next_notes;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, beat, loop_len, loop_cnt,
    input  exp_notes, step, playing, done, next_notes
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, beat, loop_len, loop_cnt,
    output exp_notes, step, playing, done, next_notes
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, start, stop, beat, loop_len, loop_cnt,
    input  exp_notes, step, playing, done
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, beat, loop_len, loop_cnt,
    output exp_notes, step, playing, done
  );
`endif
endinterface

// File: rtl/note_pattern_seq_ram.sv
// DEPTH x LANES pattern table: synchronous write, combinational read.
// NOTE_SEQ_LOOKAHEAD_EN adds a second read port for the look-ahead step.
module note_pattern_ram #(
  parameter int LANES  = note_pkg::NOTE_LANES,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [LANES-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [LANES-1:0]  rdata
`ifdef NOTE_SEQ_LOOKAHEAD_EN
  ,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [LANES-1:0]  rdata_b
`endif
);
  logic [LANES-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
`ifdef NOTE_SEQ_LOOKAHEAD_EN
  assign rdata_b = mem[raddr_b];
`endif
endmodule

// File: rtl/note_pattern_seq.sv
// Beat-driven note pattern sequencer: table playback with programmable loop length and repeat count.
// Optional macro NOTE_SEQ_LOOKAHEAD_EN adds the registered next_notes output.
module note_pattern_seq
  import note_pkg::*;
#(
  parameter int LANES  = NOTE_LANES,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LOOP_W = 8
) (
  input  logic clk,
  input  logic resetn,
  note_pattern_seq_if.slave bus
);
  state_t            state;
  logic [ADDR_W-1:0] step, step_nx;
  logic [LOOP_W-1:0] loops, loops_inc;
  logic [LOOP_W:0]   loops_p1;
  logic              wrap, last_loop, ram_we;
  logic [LANES-1:0]  rd_cur, exp_notes;

  assign ram_we = bus.wr_en && (state == IDLE);

  always_comb begin
    // An all-ones step also wraps, covering loop_len dropping below the current step.
    wrap      = (step == bus.loop_len) || (&step);
    step_nx   = wrap ? '0 : step + 1'b1;
    loops_inc = (&loops) ? loops : loops + 1'b1;
    loops_p1  = {1'b0, loops} + 1'b1;
    last_loop = (bus.loop_cnt != '0) && (loops_p1 == {1'b0, bus.loop_cnt});
  end

`ifdef NOTE_SEQ_LOOKAHEAD_EN
  logic [LANES-1:0] rd_next, next_notes;

  note_pattern_ram #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .we(ram_we), .waddr(bus.wr_addr), .wdata(bus.wr_data),
    .raddr(step), .rdata(rd_cur), .raddr_b(step_nx), .rdata_b(rd_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) next_notes <= '0;
    else         next_notes <= (state == PLAY && !bus.stop) ? rd_next : '0;
  end

  assign bus.next_notes = next_notes;
`else
  note_pattern_ram #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .we(ram_we), .waddr(bus.wr_addr), .wdata(bus.wr_data),
    .raddr(step), .rdata(rd_cur)
  );
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      step      <= '0;
      loops     <= '0;
      exp_notes <= '0;
    end else begin
      // stop clears the note output together with the state, so IDLE never shows a stale step.
      exp_notes <= (state == PLAY && !bus.stop) ? rd_cur : '0;
      if (bus.stop) begin
        state <= IDLE;
        step  <= '0;
        loops <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state <= PLAY;
              step  <= '0;
              loops <= '0;
            end
          end
          PLAY: begin
            if (bus.beat) begin
              step <= step_nx;
              if (wrap) begin
                loops <= loops_inc;
                if (last_loop) state <= DONE;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.exp_notes = exp_notes;
  assign bus.step      = step;
  assign bus.playing   = (state == PLAY);
  assign bus.done      = (state == DONE);
endmodule
